// File: rtl/load_store_unit.sv
// load_store_unit
// CPU-side initiator for data-memory loads and stores. Accepts one command
// from the execute stage, drives a registered req/ack memory bus with a
// word-aligned address, byte enables and lane-aligned write data, then
// returns the extended load result with a one-cycle done pulse.
//
// Build option: LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are split into two word transactions
//   undefined - misaligned accesses finish at once with err=1, no bus traffic
//
// Ports:
//   clk_cpu, reset                 clock, asynchronous active-low reset
//   start, op, adrs, wdata         command from execute stage
//   busy, done, err, rdata         status and load result to the pipeline
//   mem_req, mem_we, mem_adrs,     registered memory request bus
//   mem_be, mem_wdata
//   mem_ack, mem_rdata             memory response
//
// Opcode codes come from src/defines.v; fallback values are provided so the
// block also elaborates on its own.

`ifndef OP_lb
`define OP_lb  6'h20
`define OP_lh  6'h21
`define OP_lw  6'h23
`define OP_lbu 6'h24
`define OP_lhu 6'h25
`define OP_sb  6'h28
`define OP_sh  6'h29
`define OP_sw  6'h2B
`endif

module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_cpu,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic [31:0] adrs,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_adrs,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC0 = 2'd1;
   localparam logic [1:0] ST_ACC1 = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   // Timeout fires on the edge that would make the wait count equal TIMEOUT.
   localparam logic        TMO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;
   localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   logic [1:0]  state_r;
   logic [1:0]  size_r;
   logic        sign_r;
   logic [1:0]  off_r;
   logic        split_r;
   logic [3:0]  be_hi_r;
   logic [31:0] wd_hi_r;
   logic [31:0] word0_r;
   logic [31:0] tmo_cnt_r;

   logic        legal_s;
   logic        store_s;
   logic        sign_s;
   logic [1:0]  size_s;
   logic [3:0]  be_base_s;
   logic [31:0] wmask_s;
   logic [7:0]  be8_s;
   logic [63:0] wd64_s;
   logic        split_need_s;
   logic [63:0] ld64_s;
   logic [31:0] ld_word_s;
   logic [31:0] ld_ext_s;

   // Sign- or zero-extend the lane-shifted load word to 32 bits.
   function automatic logic [31:0] extend(input logic [31:0] w,
                                          input logic [1:0]  sz,
                                          input logic        sgn);
      logic [31:0] r;
      case (sz)
         SZ_B:    r = sgn ? {{24{w[7]}}, w[7:0]} : {24'h000000, w[7:0]};
         SZ_H:    r = sgn ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   // Opcode decode: legality, direction, size and signedness.
   always_comb begin
      legal_s = 1'b0;
      store_s = 1'b0;
      sign_s  = 1'b0;
      size_s  = SZ_W;
      case (op)
         `OP_lb:  begin legal_s = 1'b1; sign_s = 1'b1; size_s = SZ_B; end
         `OP_lh:  begin legal_s = 1'b1; sign_s = 1'b1; size_s = SZ_H; end
         `OP_lw:  begin legal_s = 1'b1; size_s = SZ_W; end
         `OP_lbu: begin legal_s = 1'b1; size_s = SZ_B; end
         `OP_lhu: begin legal_s = 1'b1; size_s = SZ_H; end
         `OP_sb:  begin legal_s = 1'b1; store_s = 1'b1; size_s = SZ_B; end
         `OP_sh:  begin legal_s = 1'b1; store_s = 1'b1; size_s = SZ_H; end
         `OP_sw:  begin legal_s = 1'b1; store_s = 1'b1; size_s = SZ_W; end
         default: begin legal_s = 1'b0; end
      endcase
   end

   // Lane placement over a two-word window: the low half goes out in ACC0,
   // anything spilling into the high half needs a second access in ACC1.
   always_comb begin
      be_base_s = 4'b1111;
      wmask_s   = 32'hFFFF_FFFF;
      case (size_s)
         SZ_B:    begin be_base_s = 4'b0001; wmask_s = 32'h0000_00FF; end
         SZ_H:    begin be_base_s = 4'b0011; wmask_s = 32'h0000_FFFF; end
         default: begin be_base_s = 4'b1111; wmask_s = 32'hFFFF_FFFF; end
      endcase
      be8_s        = 8'({4'b0000, be_base_s} << adrs[1:0]);
      wd64_s       = store_s ? ({32'h0000_0000, wdata & wmask_s} << {adrs[1:0], 3'b000})
                             : 64'h0;
      split_need_s = |be8_s[7:4];
   end

   // Load assembly: in ACC1 the first word sits in the low half of the window.
   always_comb begin
      ld64_s    = (state_r == ST_ACC1) ? {mem_rdata, word0_r} : {32'h0000_0000, mem_rdata};
      ld_word_s = 32'(ld64_s >> {off_r, 3'b000});
      ld_ext_s  = extend(ld_word_s, size_r, sign_r);
   end

   // Control FSM with registered bus and status outputs.
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         size_r    <= 2'd0;
         sign_r    <= 1'b0;
         off_r     <= 2'd0;
         split_r   <= 1'b0;
         be_hi_r   <= 4'd0;
         wd_hi_r   <= 32'd0;
         word0_r   <= 32'd0;
         tmo_cnt_r <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_adrs  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (start) begin
                  size_r  <= size_s;
                  sign_r  <= sign_s;
                  off_r   <= adrs[1:0];
                  split_r <= split_need_s;
                  be_hi_r <= be8_s[7:4];
                  wd_hi_r <= wd64_s[63:32];
                  if (!legal_s || (split_need_s && !SPLIT_EN)) begin
                     state_r <= ST_FIN;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     state_r   <= ST_ACC0;
                     busy      <= 1'b1;
                     mem_req   <= 1'b1;
                     mem_we    <= store_s;
                     mem_adrs  <= {adrs[31:2], 2'b00};
                     mem_be    <= be8_s[3:0];
                     mem_wdata <= wd64_s[31:0];
                     tmo_cnt_r <= 32'd0;
                  end
               end
            end
            ST_ACC0, ST_ACC1: begin
               // An ack in the expiry cycle takes priority over the timeout.
               if (mem_ack) begin
                  tmo_cnt_r <= 32'd0;
                  if ((state_r == ST_ACC0) && split_r) begin
                     state_r   <= ST_ACC1;
                     word0_r   <= mem_rdata;
                     mem_adrs  <= mem_adrs + 32'd4;
                     mem_be    <= be_hi_r;
                     mem_wdata <= wd_hi_r;
                  end else begin
                     state_r   <= ST_FIN;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     err       <= 1'b0;
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                     mem_be    <= 4'd0;
                     mem_wdata <= 32'd0;
                     if (!mem_we) begin
                        rdata <= ld_ext_s;
                     end
                  end
               end else if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
                  state_r   <= ST_FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= 4'd0;
                  mem_wdata <= 32'd0;
                  tmo_cnt_r <= 32'd0;
               end else if (TMO_EN) begin
                  tmo_cnt_r <= tmo_cnt_r + 32'd1;
               end else begin
                  tmo_cnt_r <= 32'd0;
               end
            end
            ST_FIN: begin
               done    <= 1'b0;
               err     <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               err     <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Table-driven bench for load_store_unit with a wait-state programmable
// memory responder, a bus-transaction scoreboard and a completion scoreboard.
// Hand sequences cover timeout and asynchronous reset during an access.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined.

`timescale 1ns/1ps

module tb_load_store_unit;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BAD = 6'h3F;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk_cpu;
   logic        reset;
   logic        start;
   logic [5:0]  op;
   logic [31:0] adrs;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_adrs;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk_cpu   (clk_cpu),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .adrs      (adrs),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_adrs  (mem_adrs),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk_cpu = 1'b0;
   always #5 clk_cpu = ~clk_cpu;

   // Responder: ack after wait_cfg cycles of mem_req, return word from mem_m.
   logic        ack_en;
   int          wait_cfg;
   int          wcnt = 0;
   logic [31:0] mem_m [0:255];

   assign mem_ack   = ack_en && mem_req && (wcnt == wait_cfg);
   assign mem_rdata = mem_ack ? mem_m[mem_adrs[9:2]] : 32'h0;

   always @(posedge clk_cpu) begin
      if (!mem_req || mem_ack) wcnt <= 0;
      else                     wcnt <= wcnt + 1;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } bus_t;

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
   } cmp_t;

   bus_t bus_q[$];
   cmp_t cmp_q[$];
   bus_t be_e;
   cmp_t ce_e;
   logic [31:0] model_rd;

   // Scoreboards: bus fields must match (and hold while waiting); done pops result.
   always @(negedge clk_cpu) begin
      if (reset && mem_req) begin
         if (bus_q.size() == 0) begin
            chk("unexpected_req", {31'h0, mem_req}, 32'h0);
         end else begin
            be_e = bus_q[0];
            chk(mem_ack ? "bus_we"   : "hold_we",   {31'h0, mem_we}, {31'h0, be_e.we});
            chk(mem_ack ? "bus_adrs" : "hold_adrs", mem_adrs, be_e.a);
            chk(mem_ack ? "bus_be"   : "hold_be",   {28'h0, mem_be}, {28'h0, be_e.be});
            chk(mem_ack ? "bus_wdata": "hold_wdata", mem_wdata, be_e.d);
            if (mem_ack) void'(bus_q.pop_front());
         end
      end
      if (reset && done) begin
         if (cmp_q.size() == 0) begin
            chk("unexpected_done", {31'h0, done}, 32'h0);
         end else begin
            ce_e = cmp_q.pop_front();
            chk("done_err",   {31'h0, err}, {31'h0, ce_e.err});
            chk("done_rdata", rdata, ce_e.rd);
            chk("done_busy",  {31'h0, busy}, 32'h0);
         end
      end
   end

   typedef struct {
      string       nm;
      logic [5:0]  op;
      logic [31:0] adrs;
      logic [31:0] wdata;
      logic [31:0] w0;
      logic [31:0] w1;
      int          waits;
      int          nbus;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] d1;
      logic        ld;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[12];

   task automatic run_vec(input vec_t v);
      int lat;
      int exp_lat;
      int idx;
      @(negedge clk_cpu);
      idx = int'(v.adrs[9:2]);
      mem_m[idx]             = v.w0;
      mem_m[(idx + 1) % 256] = v.w1;
      wait_cfg = v.waits;
      if (v.nbus > 0) bus_q.push_back('{~v.ld, v.a0, v.be0, v.d0});
      if (v.nbus > 1) bus_q.push_back('{~v.ld, v.a1, v.be1, v.d1});
      if (v.ld && !v.err) model_rd = v.rd;
      cmp_q.push_back('{v.err, model_rd});
      start = 1'b1;
      op    = v.op;
      adrs  = v.adrs;
      wdata = v.wdata;
      @(posedge clk_cpu);
      #1 start = 1'b0;
      exp_lat = 1 + v.nbus * (v.waits + 1);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk_cpu);
         if (i == 1) chk({v.nm, "_busy"}, {31'h0, busy}, {31'h0, (v.nbus > 0)});
         if (done) begin
            lat = i;
            break;
         end
      end
      chk({v.nm, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      int nreq;
      int lat;
      reset    = 1'b0;
      start    = 1'b0;
      op       = 6'h0;
      adrs     = 32'h0;
      wdata    = 32'h0;
      ack_en   = 1'b1;
      wait_cfg = 0;
      model_rd = 32'h0;
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;

      repeat (2) @(negedge clk_cpu);
      chk("rst_busy",      {31'h0, busy}, 32'h0);
      chk("rst_done",      {31'h0, done}, 32'h0);
      chk("rst_err",       {31'h0, err}, 32'h0);
      chk("rst_rdata",     rdata, 32'h0);
      chk("rst_mem_req",   {31'h0, mem_req}, 32'h0);
      chk("rst_mem_we",    {31'h0, mem_we}, 32'h0);
      chk("rst_mem_adrs",  mem_adrs, 32'h0);
      chk("rst_mem_be",    {28'h0, mem_be}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      reset = 1'b1;

      vecs[0]  = '{"lw_al",  OP_LW,  32'h100, 32'h0, 32'h12345678, 32'h0, 0, 1,
                   32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h12345678};
      vecs[1]  = '{"lb_103", OP_LB,  32'h103, 32'h0, 32'h80FF1234, 32'h0, 0, 1,
                   32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80};
      vecs[2]  = '{"lbu_103", OP_LBU, 32'h103, 32'h0, 32'h80FF1234, 32'h0, 1, 1,
                   32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h00000080};
      vecs[3]  = '{"sh_102", OP_SH,  32'h102, 32'h0000ABCD, 32'h0, 32'h0, 3, 1,
                   32'h100, 4'hC, 32'hABCD0000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{"lh_102", OP_LH,  32'h102, 32'h0, 32'h80011234, 32'h0, 2, 1,
                   32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF8001};
      vecs[5]  = '{"lhu_100", OP_LHU, 32'h100, 32'h0, 32'h1234F00D, 32'h0, 0, 1,
                   32'h100, 4'h3, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000F00D};
      vecs[6]  = '{"sb_101", OP_SB,  32'h101, 32'hFFFFFF5A, 32'h0, 32'h0, 0, 1,
                   32'h100, 4'h2, 32'h00005A00, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{"sw_104", OP_SW,  32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 1, 1,
                   32'h104, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{"lw_101", OP_LW,  32'h101, 32'h0, 32'h44332211, 32'h88776655, 0, SPLIT ? 2 : 0,
                   32'h100, 4'hE, 32'h0, 32'h104, 4'h1, 32'h0, 1'b1, !SPLIT, 32'h55443322};
      vecs[9]  = '{"bad_op", OP_BAD, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0,
                   32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0};
      vecs[10] = '{"lh_103", OP_LH,  32'h103, 32'h0, 32'h80112233, 32'h445566F7, 1, SPLIT ? 2 : 0,
                   32'h100, 4'h8, 32'h0, 32'h104, 4'h1, 32'h0, 1'b1, !SPLIT, 32'hFFFFF780};
      vecs[11] = '{"sw_102", OP_SW,  32'h102, 32'h11223344, 32'h0, 32'h0, 2, SPLIT ? 2 : 0,
                   32'h100, 4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122, 1'b0, !SPLIT, 32'h0};

      for (int k = 0; k < 12; k++) run_vec(vecs[k]);

      // Timeout: no ack, mem_req held for exactly 4 cycles, then done+err.
      @(negedge clk_cpu);
      ack_en = 1'b0;
      bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
      cmp_q.push_back('{1'b1, model_rd});
      start = 1'b1; op = OP_LW; adrs = 32'h100; wdata = 32'h0;
      @(posedge clk_cpu);
      #1 start = 1'b0;
      nreq = 0;
      lat  = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk_cpu);
         if (mem_req) nreq++;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("tmo_req_cycles", 32'(nreq), 32'd4);
      chk("tmo_done_cycle", 32'(lat), 32'd5);
      bus_q.delete();
      ack_en = 1'b1;

      // Asynchronous reset while ACC0 holds mem_req.
      @(negedge clk_cpu);
      ack_en = 1'b0;
      bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
      start = 1'b1; op = OP_LW; adrs = 32'h100;
      @(posedge clk_cpu);
      #1 start = 1'b0;
      @(negedge clk_cpu);
      chk("arst_pre_req", {31'h0, mem_req}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("arst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("arst_busy",    {31'h0, busy}, 32'h0);
      chk("arst_done",    {31'h0, done}, 32'h0);
      chk("arst_rdata",   rdata, 32'h0);
      bus_q.delete();
      cmp_q.delete();
      model_rd = 32'h0;
      ack_en   = 1'b1;
      @(negedge clk_cpu);
      reset = 1'b1;
      run_vec(vecs[0]);

      repeat (3) @(negedge clk_cpu);
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("cmp_q_drained", 32'(cmp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
